// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types, defaults and error rule for the APB register-memory completer
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEPTH_DEF   = 64;
    localparam int RO_BASE_DEF = 56;
    localparam int WAIT_W      = 4;

    // An access errors when it misses the array or writes into the read-only tail.
    function automatic logic addr_err(input logic [31:0] addr, input logic write,
                                      input int depth, input int ro_base);
        return (addr >= 32'(depth)) || (write && (addr >= 32'(ro_base)));
    endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - word array with read-only index pattern, sync write and comb read
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int RO_BASE    = RO_BASE_DEF,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Read-only words come out of reset holding their own index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (i >= RO_BASE) ? DATA_WIDTH'(i) : '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer with wait states, error response and saturating error count
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int RO_BASE    = RO_BASE_DEF
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [WAIT_W-1:0]     wait_cfg,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR,
    output logic [7:0]            err_cnt
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t                state, next_state;
    logic [WAIT_W-1:0]     cnt;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic                  cap_write;
    logic [DATA_WIDTH-1:0] cap_wdata;

    logic                  setup, live_err, cap_err;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_write, sel_err;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ready_d, slverr_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  wr_en;

    assign setup    = PSELx & ~PENABLE;
    assign live_err = addr_err(32'(PADDR), PWRITE, DEPTH, RO_BASE);
    assign cap_err  = addr_err(32'(cap_addr), cap_write, DEPTH, RO_BASE);

    // A zero-wait transfer enters DONE straight from IDLE, so it must use the live bus fields.
    assign sel_addr  = (state == IDLE) ? PADDR  : cap_addr;
    assign sel_write = (state == IDLE) ? PWRITE : cap_write;
    assign sel_err   = (state == IDLE) ? live_err : cap_err;

    assign wr_en = (state == DONE) & PSELx & cap_write & ~cap_err;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (setup) begin
                    next_state = (wait_cfg == '0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (!PSELx) begin
                    next_state = IDLE;
                end else if (PENABLE && cnt == WAIT_W'(1)) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ready_d  = 1'b0;
        slverr_d = 1'b0;
        rdata_d  = '0;
        if (next_state == DONE) begin
            ready_d  = 1'b1;
            slverr_d = sel_err;
            rdata_d  = (!sel_write && !sel_err) ? rd_data : '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            PREADY  <= ready_d;
            PSLVERR <= slverr_d;
            PRDATA  <= rdata_d;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt       <= '0;
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
        end else if (state == IDLE && setup) begin
            cnt       <= wait_cfg;
            cap_addr  <= PADDR;
            cap_write <= PWRITE;
            cap_wdata <= PWDATA;
        end else if (state == WAIT && PSELx && PENABLE) begin
            cnt <= cnt - WAIT_W'(1);
        end
    end

    // Only a completed (non-aborted) error response counts.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            err_cnt <= '0;
        end else if (state == DONE && PSELx && PSLVERR && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    apb_slave_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .RO_BASE    (RO_BASE),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .wr_en   (wr_en),
        .wr_idx  (cap_addr[IDX_W-1:0]),
        .wr_data (cap_wdata),
        .rd_idx  (sel_addr[IDX_W-1:0]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - directed and random APB transfers against a reference memory model
module tb_apb_slave_mem;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSELx = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [7:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [3:0]  wait_cfg = '0;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ref_mem [64];
    int          ref_err_cnt;

    always #5 PCLK = ~PCLK;

    apb_slave_mem dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PSELx    (PSELx),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .wait_cfg (wait_cfg),
        .PREADY   (PREADY),
        .PRDATA   (PRDATA),
        .PSLVERR  (PSLVERR),
        .err_cnt  (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = (i >= 56) ? 32'(i) : 32'd0;
        ref_err_cnt = 0;
    endfunction

    function automatic logic model_err(input int addr, input logic wr);
        return (addr >= 64) || (wr && addr >= 56);
    endfunction

    // Caller is positioned just after a rising edge with the FSM in IDLE.
    task automatic xfer(input logic wr, input int addr, input logic [31:0] wd, input int w,
                        input string tag, output logic [31:0] rd);
        logic        e;
        logic [31:0] exp_rd;
        e      = model_err(addr, wr);
        exp_rd = (!wr && !e) ? ref_mem[addr] : 32'd0;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = 8'(addr); PWDATA = wd;
        wait_cfg = 4'(w);
        @(posedge PCLK); #1;
        PENABLE  = 1'b1;
        wait_cfg = 4'($urandom);
        for (int k = 0; k <= w; k++) begin
            @(negedge PCLK);
            if (k < w) begin
                chk({tag, " pready_wait"}, {31'd0, PREADY}, 32'd0);
                chk({tag, " prdata_wait"}, PRDATA, 32'd0);
            end else begin
                chk({tag, " pready_last"}, {31'd0, PREADY}, 32'd1);
                chk({tag, " pslverr"}, {31'd0, PSLVERR}, {31'd0, e});
                chk({tag, " prdata"}, PRDATA, exp_rd);
            end
            rd = PRDATA;
            @(posedge PCLK); #1;
        end
        PSELx = 1'b0; PENABLE = 1'b0;
        if (wr && !e) ref_mem[addr] = wd;
        if (e && ref_err_cnt < 255) ref_err_cnt++;
        chk({tag, " pready_after"}, {31'd0, PREADY}, 32'd0);
        chk({tag, " err_cnt"}, {24'd0, err_cnt}, 32'(ref_err_cnt));
    endtask

    initial begin
        logic [31:0] rd;
        model_reset();
        #12;
        chk("reset pready", {31'd0, PREADY}, 32'd0);
        chk("reset prdata", PRDATA, 32'd0);
        chk("reset pslverr", {31'd0, PSLVERR}, 32'd0);
        chk("reset err_cnt", {24'd0, err_cnt}, 32'd0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // PENABLE alone in IDLE must not start a transfer
        PSELx = 1'b1; PENABLE = 1'b1; PADDR = 8'd5;
        repeat (2) begin
            @(negedge PCLK);
            chk("stray penable pready", {31'd0, PREADY}, 32'd0);
        end
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0;

        xfer(1'b1, 5, 32'h1234_5678, 0, "wr5_w0", rd);
        xfer(1'b0, 5, 32'h0, 0, "rd5_w0", rd);
        chk("rd5 value", rd, 32'h1234_5678);
        xfer(1'b0, 5, 32'h0, 3, "rd5_w3", rd);

        xfer(1'b1, 60, 32'hFFFF_FFFF, 1, "wr60_ro", rd);
        xfer(1'b0, 60, 32'h0, 0, "rd60_ro", rd);
        chk("rd60 value", rd, 32'h0000_003C);
        chk("err_cnt one", {24'd0, err_cnt}, 32'd1);

        // abort a write to 7 after two PENABLE cycles
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd7; PWDATA = 32'hDEAD_BEEF;
        wait_cfg = 4'd4;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        PSELx = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        chk("abort pready", {31'd0, PREADY}, 32'd0);
        chk("abort err_cnt", {24'd0, err_cnt}, 32'(ref_err_cnt));
        xfer(1'b0, 7, 32'h0, 2, "rd7_after_abort", rd);
        chk("rd7 value", rd, 32'd0);

        for (int i = 0; i < 40; i++) begin
            xfer(1'($urandom), int'($urandom_range(0, 80)), $urandom,
                 int'($urandom_range(0, 3)), $sformatf("rand%0d", i), rd);
        end

        for (int i = 0; i < 300; i++) begin
            xfer(1'b0, 70, 32'h0, 0, "rd70_oob", rd);
        end
        chk("err_cnt saturated", {24'd0, err_cnt}, 32'd255);

        xfer(1'b1, 5, 32'hA5A5_0001, 0, "wr5_pre_reset", rd);
        // reset asserted while a write waits in WAIT
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd9; PWDATA = 32'h5555_AAAA;
        wait_cfg = 4'd4;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #3;
        PRESETn = 1'b0;
        #1;
        chk("midreset pready", {31'd0, PREADY}, 32'd0);
        chk("midreset prdata", PRDATA, 32'd0);
        chk("midreset pslverr", {31'd0, PSLVERR}, 32'd0);
        chk("midreset err_cnt", {24'd0, err_cnt}, 32'd0);
        PSELx = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        model_reset();
        @(posedge PCLK); #1;
        xfer(1'b0, 5, 32'h0, 1, "rd5_post_reset", rd);
        chk("rd5 post reset", rd, 32'd0);
        xfer(1'b0, 9, 32'h0, 0, "rd9_post_reset", rd);
        xfer(1'b0, 56, 32'h0, 0, "rd56_post_reset", rd);
        chk("rd56 post reset", rd, 32'd56);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer (slave) with a word-addressed register memory, programmable wait states and error signalling. It sits directly downstream of the APB master FSM, where the master drives PSELx/PENABLE/PWRITE/PADDR/PWDATA and this block returns PREADY/PRDATA/PSLVERR. It is the default DUT-side target for the APB VIP benches, and it also serves as a standalone synthesizable memory-mapped register bank.

## Interface
Parameters:
- DATA_WIDTH, 32, PRDATA/PWDATA width; driven from `DATA_WIDTH.
- ADDR_WIDTH, 8, PADDR width; driven from `ADDR_WIDTH.
- DEPTH, 64, number of words. PADDR is a word index.
- RO_BASE, 56, first read-only word index. Words RO_BASE..DEPTH-1 are read-only.

Ports:
- PCLK, input, 1, clock. Single clock domain.
- PRESETn, input, 1, asynchronous active-low reset.
- PSELx, input, 1, slave select.
- PENABLE, input, 1, access phase.
- PWRITE, input, 1, 1 = write, 0 = read.
- PADDR, input, ADDR_WIDTH, word address.
- PWDATA, input, DATA_WIDTH, write data.
- wait_cfg, input, 4, number of wait states. Sampled at the setup edge.
- PREADY, output, 1, transfer completes in the current cycle.
- PRDATA, output, DATA_WIDTH, read data. Valid only while PREADY=1.
- PSLVERR, output, 1, error response. Valid only while PREADY=1.
- err_cnt, output, 8, count of error responses, saturating.

## Operation
- FSM states:
  - IDLE: waiting for a transfer.
  - WAIT: access phase, PREADY=0.
  - DONE: access phase, PREADY=1.
- Setup detect: on an edge in IDLE with PSELx=1 and PENABLE=0, capture PADDR, PWRITE, PWDATA and wait_cfg; load cnt=wait_cfg.
  - If wait_cfg=0, go to DONE. Otherwise go to WAIT.
- WAIT: each edge with PSELx&PENABLE decrements cnt. When cnt reaches 1 at the edge, go to DONE.
- DONE: the edge ends the transfer and the FSM always returns to IDLE. A back-to-back SETUP is then detected on the following edge.
- Error condition: err = (addr ≥ DEPTH) | (write & addr ≥ RO_BASE), evaluated on the captured fields.
- Outputs in DONE are registered, set on the edge that enters DONE:
  - PREADY=1 and PSLVERR=err.
  - PRDATA = mem[addr] for a read with !err; otherwise 0.
- Write commit: on the edge leaving DONE, if write & !err, then mem[addr]=captured PWDATA. An erroring write leaves memory unchanged.
- err_cnt: increments on the edge leaving DONE when PSLVERR=1, and holds at 255.
- Abort: PSELx=0 on any edge in WAIT or DONE forces IDLE. There is no write and no err_cnt update, and PREADY/PSLVERR/PRDATA are cleared.
- PENABLE=1 seen in IDLE without a preceding setup is ignored.
- Out-of-range reads return PRDATA=0 with PSLVERR=1.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - state=IDLE, cnt=0.
  - PREADY=0, PRDATA=0, PSLVERR=0, err_cnt=0.
  - RW words reset to 0. RO word i reads i, zero-extended.
- With wait_cfg=W, the transfer spends W+1 PENABLE cycles. PREADY is high only in the last one.
- Outside DONE: PREADY, PSLVERR and PRDATA are 0.
- A write is visible to a read whose setup edge follows the commit edge, so back-to-back write-then-read returns the new data.
- Changes to wait_cfg during a transfer have no effect.

## Structure
- The shared package apb_pkg holds:
  - the state enum (IDLE, WAIT, DONE);
  - localparam defaults for DEPTH and RO_BASE;
  - the wait_cfg width.
- Sub-module apb_slave_regfile holds the memory array, the RO reset pattern, the synchronous write port and the combinational read port. The FSM, counter, error logic and err_cnt stay in apb_slave_mem.

## Test plan
- Write 0x1234_5678 to addr 5 with wait_cfg=0, then read addr 5 → PREADY high in the first PENABLE cycle; read returns 0x1234_5678 with PSLVERR=0.
- Read addr 5 with wait_cfg=3 → PREADY stays low for 3 PENABLE cycles and goes high on the 4th with correct data; no early PRDATA.
- Write 0xFFFF_FFFF to addr 60 (RO), then read addr 60 → write gets PSLVERR=1; read returns 60 (0x3C); err_cnt=1.
- Read addr 70 (beyond DEPTH) → PSLVERR=1 and PRDATA=0. Repeat 300 times → err_cnt saturates at 255.
- Write to addr 7 with wait_cfg=4, then drop PSELx after 2 PENABLE cycles → FSM returns to IDLE; a subsequent read of addr 7 returns 0.
- Assert PRESETn low mid-WAIT after prior writes → all outputs go to 0 immediately; after release, reads of RW addresses return 0 and RO addr 56 returns 56.
